// File: rtl/uart_frame_pkg.sv
// Shared constants for the UART framing stage: FSM encodings, sync byte and error codes.
package uart_frame_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE    = 3'd0;
    localparam state_t ST_CMD     = 3'd1;
    localparam state_t ST_LEN     = 3'd2;
    localparam state_t ST_PAYLOAD = 3'd3;
    localparam state_t ST_CHK     = 3'd4;
    localparam state_t ST_DRAIN   = 3'd5;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    localparam logic [1:0] ERR_CHK = 2'd1;
    localparam logic [1:0] ERR_LEN = 2'd2;
    localparam logic [1:0] ERR_TMO = 2'd3;

    function automatic int addr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/uart_frame_buf.sv
// Payload buffer: MAX_LEN x 8 register array, synchronous write, combinational read.
module uart_frame_buf #(
    parameter int MAX_LEN = 16,
    parameter int AW      = 4
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [7:0]    wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [7:0]    rdata_o
);

    logic [7:0] mem_q [MAX_LEN];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/uart_frame_rx.sv
// Frame assembler/checker behind the UART byte receiver; releases good payloads on a stream.
// Optional inter-byte timeout is compiled in with UART_FRAME_TIMEOUT_EN.
//
// state      | meaning
// IDLE       | hunting for SYNC_BYTE
// CMD        | next byte is the command
// LEN        | next byte is the payload length
// PAYLOAD    | storing payload bytes into the buffer
// CHK        | next byte is the XOR checksum
// DRAIN      | streaming the buffered payload out
module uart_frame_rx
    import uart_frame_pkg::*;
#(
    parameter int MAX_LEN      = 16,
    parameter int TIMEOUT_CLKS = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_valid,
    input  logic [7:0] rx_byte,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_data,
    output logic       out_last,
    output logic [7:0] out_cmd,
    output logic       frame_ok,
    output logic       frame_err,
    output logic [1:0] err_code,
    output logic       overrun
);

    localparam int PTR_W = $clog2(MAX_LEN + 1);
    localparam int AW    = addr_width(MAX_LEN);

    state_t           state_q, state_d;
    logic [7:0]       cmd_q, cmd_d;
    logic [7:0]       chk_q, chk_d;
    logic [PTR_W-1:0] len_q, len_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic             ok_q, ok_d;
    logic             err_q, err_d;
    logic [1:0]       code_q, code_d;
    logic             ovr_q, ovr_d;
    logic             buf_we;
    logic [7:0]       buf_rdata;
    logic             last;
    logic             in_frame;
    logic             tmo_hit;

    assign in_frame = (state_q == ST_CMD) || (state_q == ST_LEN) ||
                      (state_q == ST_PAYLOAD) || (state_q == ST_CHK);
    assign last     = (rd_ptr_q == (len_q - PTR_W'(1)));

`ifdef UART_FRAME_TIMEOUT_EN
    localparam int TMO_W = (TIMEOUT_CLKS > 1) ? $clog2(TIMEOUT_CLKS) : 1;

    logic [TMO_W-1:0] tmo_q, tmo_d;

    assign tmo_hit = in_frame && !rx_valid && (tmo_q == TMO_W'(TIMEOUT_CLKS - 1));

    // A byte arriving on the expiry cycle wins and restarts the count.
    always_comb begin
        tmo_d = '0;
        if (in_frame && !rx_valid && !tmo_hit) begin
            tmo_d = tmo_q + TMO_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_d;
        end
    end
`else
    assign tmo_hit = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        cmd_d    = cmd_q;
        chk_d    = chk_q;
        len_d    = len_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        ok_d     = 1'b0;
        err_d    = 1'b0;
        code_d   = 2'd0;
        ovr_d    = 1'b0;
        buf_we   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (rx_valid && (rx_byte == SYNC_BYTE)) begin
                    state_d = ST_CMD;
                end
            end
            ST_CMD: begin
                if (rx_valid) begin
                    cmd_d   = rx_byte;
                    chk_d   = rx_byte;
                    state_d = ST_LEN;
                end
            end
            ST_LEN: begin
                if (rx_valid) begin
                    if (int'(rx_byte) > MAX_LEN) begin
                        err_d   = 1'b1;
                        code_d  = ERR_LEN;
                        state_d = ST_IDLE;
                    end else begin
                        len_d   = rx_byte[PTR_W-1:0];
                        chk_d   = chk_q ^ rx_byte;
                        state_d = (rx_byte == 8'd0) ? ST_CHK : ST_PAYLOAD;
                    end
                end
            end
            ST_PAYLOAD: begin
                if (rx_valid) begin
                    buf_we   = 1'b1;
                    wr_ptr_d = wr_ptr_q + PTR_W'(1);
                    chk_d    = chk_q ^ rx_byte;
                    if ((wr_ptr_q + PTR_W'(1)) == len_q) begin
                        state_d = ST_CHK;
                    end
                end
            end
            ST_CHK: begin
                if (rx_valid) begin
                    if (rx_byte == chk_q) begin
                        ok_d    = 1'b1;
                        state_d = (len_q != '0) ? ST_DRAIN : ST_IDLE;
                    end else begin
                        err_d    = 1'b1;
                        code_d   = ERR_CHK;
                        wr_ptr_d = '0;
                        state_d  = ST_IDLE;
                    end
                end
            end
            ST_DRAIN: begin
                ovr_d = rx_valid;
                if (out_ready) begin
                    if (last) begin
                        rd_ptr_d = '0;
                        wr_ptr_d = '0;
                        state_d  = ST_IDLE;
                    end else begin
                        rd_ptr_d = rd_ptr_q + PTR_W'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (tmo_hit) begin
            err_d    = 1'b1;
            code_d   = ERR_TMO;
            wr_ptr_d = '0;
            state_d  = ST_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            cmd_q    <= '0;
            chk_q    <= '0;
            len_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            ok_q     <= 1'b0;
            err_q    <= 1'b0;
            code_q   <= '0;
            ovr_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cmd_q    <= cmd_d;
            chk_q    <= chk_d;
            len_q    <= len_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            ok_q     <= ok_d;
            err_q    <= err_d;
            code_q   <= code_d;
            ovr_q    <= ovr_d;
        end
    end

    uart_frame_buf #(
        .MAX_LEN (MAX_LEN),
        .AW      (AW)
    ) u_buf (
        .clk     (clk),
        .we_i    (buf_we),
        .waddr_i (wr_ptr_q[AW-1:0]),
        .wdata_i (rx_byte),
        .raddr_i (rd_ptr_q[AW-1:0]),
        .rdata_o (buf_rdata)
    );

    // Data and last are forced low outside DRAIN so idle outputs read as zero.
    assign out_valid = (state_q == ST_DRAIN);
    assign out_data  = out_valid ? buf_rdata : 8'd0;
    assign out_last  = out_valid && last;
    assign out_cmd   = cmd_q;
    assign frame_ok  = ok_q;
    assign frame_err = err_q;
    assign err_code  = code_q;
    assign overrun   = ovr_q;

endmodule

// File: tb/tb_uart_frame_rx.sv
// Directed bench for uart_frame_rx; timeout expectations follow UART_FRAME_TIMEOUT_EN.
module tb_uart_frame_rx;

    logic       clk = 1'b0;
    logic       reset;
    logic       rx_valid;
    logic [7:0] rx_byte;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       out_last;
    logic [7:0] out_cmd;
    logic       frame_ok;
    logic       frame_err;
    logic [1:0] err_code;
    logic       overrun;

    int checks = 0;
    int errors = 0;
    int err_pulses = 0;
    int ok_pulses = 0;
    int ovr_pulses = 0;
    logic [1:0] last_code = 2'd0;
    int err_before;

    always #5 clk = ~clk;

    uart_frame_rx #(
        .MAX_LEN      (16),
        .TIMEOUT_CLKS (64)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .rx_valid  (rx_valid),
        .rx_byte   (rx_byte),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_cmd   (out_cmd),
        .frame_ok  (frame_ok),
        .frame_err (frame_err),
        .err_code  (err_code),
        .overrun   (overrun)
    );

    // Pulse tallies, sampled just after each active edge.
    always @(posedge clk) begin
        #1;
        if (frame_err) begin
            err_pulses++;
            last_code = err_code;
        end
        if (frame_ok) ok_pulses++;
        if (overrun) ovr_pulses++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] outs();
        return {9'd0, out_valid, out_last, frame_ok, frame_err, overrun, err_code, out_cmd, out_data};
    endfunction

    // Called at a negedge; returns at the next negedge with any pulse visible.
    task automatic send_byte(input logic [7:0] b);
        rx_byte  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        rx_byte  = 8'd0;
    endtask

    initial begin
        reset     = 1'b1;
        rx_valid  = 1'b0;
        rx_byte   = 8'd0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outs", outs(), 32'd0);
        reset = 1'b0;

        send_byte(8'h00);
        send_byte(8'hFF);
        check("noise_ignored", {out_valid, frame_ok, frame_err}, 3'b000);

        // good frame, backpressure, overrun
        send_byte(8'hA5); send_byte(8'h10); send_byte(8'h03);
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
        send_byte(8'h13);
        check("good_ok", frame_ok, 1'b1);
        check("good_valid", out_valid, 1'b1);
        check("good_cmd", out_cmd, 8'h10);
        check("good_d0", out_data, 8'h11);
        check("good_last0", out_last, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hold_data", {out_valid, out_last, out_cmd, out_data}, {1'b1, 1'b0, 8'h10, 8'h11});
        end
        send_byte(8'h55);
        check("overrun_pulse", overrun, 1'b1);
        check("overrun_data", out_data, 8'h11);
        @(negedge clk);
        check("overrun_single", overrun, 1'b0);
        out_ready = 1'b1;
        check("drain_d0", {out_data, out_last}, {8'h11, 1'b0});
        @(negedge clk);
        check("drain_d1", {out_data, out_last}, {8'h22, 1'b0});
        @(negedge clk);
        check("drain_d2", {out_data, out_last}, {8'h33, 1'b1});
        @(negedge clk);
        check("drain_done", out_valid, 1'b0);
        check("cmd_held", out_cmd, 8'h10);
        check("good_no_err", err_pulses, 0);
        check("good_ok_count", ok_pulses, 1);
        check("ovr_count", ovr_pulses, 1);

        // bad checksum then a good frame
        send_byte(8'hA5); send_byte(8'h10); send_byte(8'h03);
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
        send_byte(8'h14);
        check("badchk_err", {frame_err, err_code, out_valid, frame_ok}, {1'b1, 2'd1, 1'b0, 1'b0});
        @(negedge clk);
        check("badchk_after", {frame_err, out_valid}, 2'b00);
        send_byte(8'hA5); send_byte(8'h20); send_byte(8'h02);
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h21);
        check("good2_ok", {frame_ok, out_valid, out_cmd, out_data, out_last}, {1'b1, 1'b1, 8'h20, 8'h01, 1'b0});
        @(negedge clk);
        check("good2_d1", {out_valid, out_data, out_last}, {1'b1, 8'h02, 1'b1});
        @(negedge clk);
        check("good2_done", out_valid, 1'b0);

        // length errors and zero-length frame
        send_byte(8'hA5); send_byte(8'h10); send_byte(8'h20);
        check("len20_err", {frame_err, err_code}, {1'b1, 2'd2});
        send_byte(8'hA5); send_byte(8'h10); send_byte(8'h11);
        check("len17_err", {frame_err, err_code}, {1'b1, 2'd2});
        send_byte(8'hA5); send_byte(8'h07); send_byte(8'h00); send_byte(8'h07);
        check("len0_ok", {frame_ok, frame_err, out_valid, out_cmd}, {1'b1, 1'b0, 1'b0, 8'h07});
        @(negedge clk);
        check("len0_no_valid", out_valid, 1'b0);

        // maximum length: payload 0..15, xor of payload is 0 so CHK = 01^10
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h10);
        for (int i = 0; i < 16; i++) send_byte(8'(i));
        send_byte(8'h11);
        check("maxlen_ok", {frame_ok, out_valid}, 2'b11);
        for (int i = 0; i < 16; i++) begin
            check("maxlen_data", {out_valid, out_data, out_last}, {1'b1, 8'(i), (i == 15)});
            @(negedge clk);
        end
        check("maxlen_done", out_valid, 1'b0);

        // inter-byte timeout
        err_before = err_pulses;
        send_byte(8'hA5); send_byte(8'h10);
        repeat (60) @(negedge clk);
        check("tmo_not_early", err_pulses, err_before);
        repeat (10) @(negedge clk);
`ifdef UART_FRAME_TIMEOUT_EN
        check("tmo_err", err_pulses, err_before + 1);
        check("tmo_code", last_code, 2'd3);
`else
        check("tmo_absent", err_pulses, err_before);
        send_byte(8'h00); send_byte(8'h00);
        check("tmo_off_chk", {frame_err, err_code}, {1'b1, 2'd1});
`endif

        // reset mid-payload, with a byte strobe on the reset edge
        send_byte(8'hA5); send_byte(8'h30); send_byte(8'h03);
        send_byte(8'hAA); send_byte(8'hBB);
        reset    = 1'b1;
        rx_valid = 1'b1;
        rx_byte  = 8'hCC;
        @(negedge clk);
        rx_valid = 1'b0;
        rx_byte  = 8'd0;
        check("mid_reset_outs", outs(), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check("post_reset_outs", outs(), 32'd0);
        send_byte(8'hA5); send_byte(8'h30); send_byte(8'h03);
        send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC);
        send_byte(8'hEE);
        check("rst_good_ok", {frame_ok, out_valid, out_cmd, out_data}, {1'b1, 1'b1, 8'h30, 8'hAA});
        @(negedge clk);
        check("rst_good_d1", {out_data, out_last}, {8'hBB, 1'b0});
        @(negedge clk);
        check("rst_good_d2", {out_data, out_last}, {8'hCC, 1'b1});
        // byte on the final-handshake cycle is still an overrun
        rx_valid = 1'b1;
        rx_byte  = 8'h77;
        @(negedge clk);
        rx_valid = 1'b0;
        rx_byte  = 8'd0;
        check("final_hs_overrun", {overrun, out_valid}, 2'b10);
        @(negedge clk);
        check("final_idle", {out_valid, frame_ok, frame_err}, 3'b000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_frame_rx.md
# uart_frame_rx

Framing stage sitting directly downstream of the UART byte receiver. Consumes its one-cycle byte strobe and byte and hunts for the sync byte. Assembles a `SYNC, CMD, LEN, payload, CHK` frame into an internal buffer and checks the XOR checksum. Releases the payload on a valid/ready stream only when the frame is good; otherwise it reports an error code.

## Interface
Parameters:
- `MAX_LEN`, default 16: maximum payload bytes per frame; buffer depth.
- `TIMEOUT_CLKS`, default 50000: inter-byte timeout in `clk` cycles. Used only when the timeout feature is compiled in.

Ports:
- `clk`  in  1  sole clock.
- `reset`  in  1  reset; synchronous, active-high.
- `rx_valid`  in  1  one-cycle strobe, byte received (receiver `received`).
- `rx_byte`  in  8  received byte, valid when `rx_valid`=1.
- `out_valid`  out  1  payload byte available.
- `out_ready`  in  1  consumer accepts the byte when `out_valid & out_ready`.
- `out_data`  out  8  payload byte.
- `out_last`  out  1  marks the final payload byte of the frame.
- `out_cmd`  out  8  CMD of the frame being drained; stable throughout the drain.
- `frame_ok`  out  1  one-cycle pulse, good frame.
- `frame_err`  out  1  one-cycle pulse, frame rejected.
- `err_code`  out  2  reason, valid with `frame_err`: 1 = checksum, 2 = LEN > `MAX_LEN`, 3 = timeout.
- `overrun`  out  1  one-cycle pulse, byte dropped during drain.

## Operation
- Reset: state IDLE. Every output is 0; wr/rd pointers, checksum and timeout counter are 0.
- IDLE: a byte equal to `SYNC_BYTE` (0xA5) moves to CMD. Any other byte is ignored silently.
- CMD: latch the byte into `out_cmd` and set chk = byte. Next state LEN.
- LEN:
  - LEN > `MAX_LEN`: `frame_err`, code 2, go to IDLE.
  - LEN = 0: go to CHK.
  - Otherwise: store LEN, chk ^= byte, go to PAYLOAD.
  - chk is updated with LEN in every non-error case.
- PAYLOAD: write the byte to `buf[wr_ptr]`, increment wr_ptr, chk ^= byte. After LEN bytes, go to CHK.
- CHK:
  - Byte == chk and LEN > 0: `frame_ok`, go to DRAIN.
  - Byte == chk and LEN = 0: `frame_ok` only, go to IDLE.
  - Mismatch: `frame_err`, code 1, go to IDLE, buffer discarded.
- DRAIN:
  - `out_valid`=1 and `out_data` = `buf[rd_ptr]`; rd_ptr advances on each handshake.
  - `out_last`=1 when rd_ptr = LEN-1.
  - After the last handshake: go to IDLE and clear the pointers.
  - Every `rx_valid` in DRAIN, including the final-handshake cycle, pulses `overrun` and the byte is dropped.
- Checksum arithmetic: 8-bit XOR of CMD, LEN and payload; no carry.
- Pointers are sized $clog2(`MAX_LEN`+1) and never wrap within a frame.

## Timing
- `frame_ok`, `frame_err` and `overrun` are registered: they assert in the cycle after the triggering `rx_valid`.
- `out_valid` rises in the same cycle as `frame_ok`.
- Throughput: one byte per cycle while `out_ready`=1.
- While `out_valid`=1 and `out_ready`=0, `out_data`, `out_last` and `out_cmd` hold stable.
- `out_cmd` holds its value after the drain until the next CMD byte.
- Back-to-back `rx_valid` on consecutive cycles is accepted in every non-DRAIN state.
- `reset` asserted in any state returns to IDLE next edge, with all outputs 0 and in-flight pulses suppressed.

## Configuration
- `UART_FRAME_TIMEOUT_EN` defined:
  - In CMD, LEN, PAYLOAD and CHK, a counter clears on each `rx_valid` and increments otherwise.
  - Reaching `TIMEOUT_CLKS`-1 gives `frame_err`, code 3, and returns to IDLE.
  - If `rx_valid` and expiry fall in the same cycle, the byte wins and the counter clears.
  - Counter is idle in IDLE and DRAIN.
- Not defined: no counter, no timeout; code 3 never produced.

## Structure
- `uart_frame_pkg` holds:
  - state enum IDLE/CMD/LEN/PAYLOAD/CHK/DRAIN;
  - `SYNC_BYTE` = 8'hA5;
  - error-code constants `ERR_CHK`=1, `ERR_LEN`=2, `ERR_TMO`=3.
- One sub-module, `uart_frame_buf`: `MAX_LEN`x8 register array with a synchronous write port and a combinational read port.

## Test plan
- Good frame: A5 10 03 11 22 33 13 -> `frame_ok`; `out_cmd`=0x10; `out_data` 11,22,33; `out_last` on 33; `frame_err` never.
- Bad checksum: A5 10 03 11 22 33 14 -> `frame_err`, code 1; `out_valid` stays 0. Then a good frame is accepted.
- Length and zero-length:
  - Leading 00 FF are ignored.
  - A5 10 20 (`MAX_LEN`=16) -> `frame_err`, code 2 right after the LEN byte.
  - A5 07 00 07 -> `frame_ok`, no `out_valid`.
- Backpressure: in the good frame, hold `out_ready`=0 for 5 cycles -> data held stable. A byte 55 injected during drain -> `overrun` pulse; output bytes unchanged.
- Timeout: A5 10 then idle for `TIMEOUT_CLKS` -> `frame_err`, code 3 (macro on). With the macro off: no error; a subsequent 00 00 (LEN 0, CHK 0x10 mismatch) -> code 1.
- Reset after the 2nd payload byte -> all outputs 0 next cycle. A following good frame is drained correctly.
